// File: rtl/fround_sched_pkg.sv
// Shared types for the fround_sched operand scheduler: request bundle and {NV,NX} flag field.
// Struct widths follow the default double-precision configuration of fround_sched.
package fround_sched_pkg;

    localparam int unsigned FR_FLEN    = 64;
    localparam int unsigned FR_NE      = 11;
    localparam int unsigned FR_NF      = 52;
    localparam int unsigned FR_FMTBITS = 2;
    localparam int unsigned FR_LOGFLEN = 6;

    typedef struct packed {
        logic                  xs;
        logic [FR_NE-1:0]      xe;
        logic [FR_NF:0]        xm;
        logic                  xnan;
        logic                  xsnan;
        logic [FR_FMTBITS-1:0] fmt;
        logic [2:0]            frm;
        logic [FR_LOGFLEN-1:0] nf;
        logic                  nx;
    } fr_req_t;

    typedef struct packed {
        logic nv;
        logic nx;
    } fr_flags_t;

endpackage

// File: rtl/fround_sched_arb.sv
// Two-requester arbiter: prefers the requester named by i_ptr, falls back to the other.
// A constant-zero pointer yields fixed priority for requester 0.
module fround_sched_arb
(
    input  logic [1:0] i_req_valid,
    input  logic       i_ptr,
    input  logic       i_adv1,
    input  logic       i_flush,
    output logic [1:0] o_grant_c
);

    always_comb begin
        o_grant_c = 2'b00;
        if (i_adv1 && !i_flush) begin
            if (i_req_valid[i_ptr]) begin
                o_grant_c[i_ptr] = 1'b1;
            end else if (i_req_valid[~i_ptr]) begin
                o_grant_c[~i_ptr] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fround_sched.sv
// Two-stage scheduler feeding a shared round-to-integer datapath from two requesters.
// Define FROUND_SCHED_RR_EN for round-robin arbitration; default is fixed priority (requester 0).
module fround_sched
    import fround_sched_pkg::*;
#(
    parameter int unsigned FLEN    = FR_FLEN,
    parameter int unsigned NE      = FR_NE,
    parameter int unsigned NF      = FR_NF,
    parameter int unsigned FMTBITS = FR_FMTBITS,
    parameter int unsigned LOGFLEN = FR_LOGFLEN
)
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic [1:0]                  ReqValid,
    output logic [1:0]                  ReqReady,
    input  logic [1:0]                  ReqXs,
    input  logic [1:0][NE-1:0]          ReqXe,
    input  logic [1:0][NF:0]            ReqXm,
    input  logic [1:0]                  ReqXNaN,
    input  logic [1:0]                  ReqXSNaN,
    input  logic [1:0][FMTBITS-1:0]     ReqFmt,
    input  logic [1:0][2:0]             ReqFrm,
    input  logic [1:0][LOGFLEN-1:0]     ReqNf,
    input  logic [1:0]                  ReqNX,
    output logic                        FrXs,
    output logic [NE-1:0]               FrXe,
    output logic [NF:0]                 FrXm,
    output logic                        FrXNaN,
    output logic                        FrXSNaN,
    output logic [FMTBITS-1:0]          FrFmt,
    output logic [2:0]                  FrFrm,
    output logic [LOGFLEN-1:0]          FrNf,
    output logic                        FrNX,
    input  logic [FLEN-1:0]             FRound,
    input  logic                        FRoundNV,
    input  logic                        FRoundNX,
    output logic                        RspValid,
    input  logic                        RspReady,
    output logic [FLEN-1:0]             RspRes,
    output logic [1:0]                  RspFlags,
    output logic                        RspTag,
    input  logic                        Flush,
    output logic                        Busy
);

    fr_req_t        w_req [2];
    fr_req_t        r_s1;
    logic           r_s1_valid;
    logic           r_s1_tag;
    logic           r_s2_valid;
    logic [FLEN-1:0] r_s2_res;
    fr_flags_t      r_s2_flags;
    logic           r_s2_tag;
    logic           w_adv1;
    logic           w_adv2;
    logic           w_kill;
    logic           w_ptr;
    logic           w_hs;
    logic           w_sel;
    logic [1:0]     w_grant_c;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_req[i].xs    = ReqXs[i];
            w_req[i].xe    = ReqXe[i];
            w_req[i].xm    = ReqXm[i];
            w_req[i].xnan  = ReqXNaN[i];
            w_req[i].xsnan = ReqXSNaN[i];
            w_req[i].fmt   = ReqFmt[i];
            w_req[i].frm   = ReqFrm[i];
            w_req[i].nf    = ReqNf[i];
            w_req[i].nx    = ReqNX[i];
        end
    end

    assign w_adv2 = ~r_s2_valid | RspReady;
    assign w_adv1 = ~r_s1_valid | w_adv2;
    // Reset also blocks acceptance so ReqReady reads 0 the moment reset rises.
    assign w_kill = Flush | reset;

    fround_sched_arb u_arb (
        .i_req_valid (ReqValid),
        .i_ptr       (w_ptr),
        .i_adv1      (w_adv1),
        .i_flush     (w_kill),
        .o_grant_c   (w_grant_c)
    );

    assign ReqReady = w_grant_c & {2{w_adv1}};
    assign w_hs     = |(ReqValid & ReqReady);
    assign w_sel    = ReqReady[1];

`ifdef FROUND_SCHED_RR_EN
    logic r_ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= 1'b0;
        end else if (w_hs) begin
            r_ptr <= ~r_ptr;
        end
    end

    assign w_ptr = r_ptr;
`else
    assign w_ptr = 1'b0;
`endif

    // S1: operand register driving the datapath.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_tag   <= 1'b0;
            r_s1       <= '0;
        end else if (Flush) begin
            r_s1_valid <= 1'b0;
        end else if (w_hs) begin
            r_s1_valid <= 1'b1;
            r_s1_tag   <= w_sel;
            r_s1       <= w_req[w_sel];
        end else if (w_adv1) begin
            r_s1_valid <= 1'b0;
        end
    end

    // S2: result register capturing datapath output, flags and originating tag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s2_valid <= 1'b0;
            r_s2_res   <= '0;
            r_s2_flags <= '0;
            r_s2_tag   <= 1'b0;
        end else if (Flush) begin
            r_s2_valid <= 1'b0;
        end else if (r_s1_valid && w_adv2) begin
            r_s2_valid    <= 1'b1;
            r_s2_res      <= FRound;
            r_s2_flags.nv <= FRoundNV;
            r_s2_flags.nx <= FRoundNX;
            r_s2_tag      <= r_s1_tag;
        end else if (RspReady) begin
            r_s2_valid <= 1'b0;
        end
    end

    assign FrXs    = r_s1.xs;
    assign FrXe    = r_s1.xe;
    assign FrXm    = r_s1.xm;
    assign FrXNaN  = r_s1.xnan;
    assign FrXSNaN = r_s1.xsnan;
    assign FrFmt   = r_s1.fmt;
    assign FrFrm   = r_s1.frm;
    assign FrNf    = r_s1.nf;
    assign FrNX    = r_s1.nx;

    assign RspValid = r_s2_valid;
    assign RspRes   = r_s2_res;
    assign RspFlags = r_s2_flags;
    assign RspTag   = r_s2_tag;
    assign Busy     = r_s1_valid | r_s2_valid;

endmodule

// File: tb/tb_fround_sched.sv
// Scoreboard bench for fround_sched with a behavioural round-to-integer datapath stand-in.
// Honours FROUND_SCHED_RR_EN the same way the design does.
module tb_fround_sched;
    import fround_sched_pkg::*;

    localparam int unsigned FLEN    = 64;
    localparam int unsigned NE      = 11;
    localparam int unsigned NF      = 52;
    localparam int unsigned FMTBITS = 2;
    localparam int unsigned LOGFLEN = 6;
    localparam int unsigned CW      = FLEN + 3;
    localparam int          BIAS    = 1023;
    localparam logic [FMTBITS-1:0] FMT_D = 2'b01;
    localparam logic [FLEN-1:0] QNAN  = 64'h7FF8_0000_0000_0000;
    localparam logic [FLEN-1:0] BOXED = 64'hFFFF_FFFF_7FC0_0000;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [1:0]              ReqValid;
    logic [1:0]              ReqReady;
    logic [1:0]              ReqXs;
    logic [1:0][NE-1:0]      ReqXe;
    logic [1:0][NF:0]        ReqXm;
    logic [1:0]              ReqXNaN;
    logic [1:0]              ReqXSNaN;
    logic [1:0][FMTBITS-1:0] ReqFmt;
    logic [1:0][2:0]         ReqFrm;
    logic [1:0][LOGFLEN-1:0] ReqNf;
    logic [1:0]              ReqNX;
    logic                    FrXs;
    logic [NE-1:0]           FrXe;
    logic [NF:0]             FrXm;
    logic                    FrXNaN;
    logic                    FrXSNaN;
    logic [FMTBITS-1:0]      FrFmt;
    logic [2:0]              FrFrm;
    logic [LOGFLEN-1:0]      FrNf;
    logic                    FrNX;
    logic [FLEN-1:0]         FRound;
    logic                    FRoundNV;
    logic                    FRoundNX;
    logic                    RspValid;
    logic                    RspReady;
    logic [FLEN-1:0]         RspRes;
    logic [1:0]              RspFlags;
    logic                    RspTag;
    logic                    Flush;
    logic                    Busy;

    typedef struct {
        logic [FLEN-1:0] res;
        logic [1:0]      flags;
        logic            tag;
    } exp_t;

    exp_t       exp_q[$];
    fr_req_t    drv [2];
    fr_req_t    w_fr;
    int         errors = 0;
    int         checks = 0;
    logic       m_ptr;
    logic [1:0] last_rdy;
    logic       last_vld;
    logic [FLEN-1:0] last_res;
    logic [1:0] last_fl;
    logic       last_tag;
    logic       last_busy;
    logic [1:0] want [4];

    always #5 clk = ~clk;

    fround_sched #(
        .FLEN(FLEN), .NE(NE), .NF(NF), .FMTBITS(FMTBITS), .LOGFLEN(LOGFLEN)
    ) dut (
        .clk(clk), .reset(reset),
        .ReqValid(ReqValid), .ReqReady(ReqReady),
        .ReqXs(ReqXs), .ReqXe(ReqXe), .ReqXm(ReqXm), .ReqXNaN(ReqXNaN), .ReqXSNaN(ReqXSNaN),
        .ReqFmt(ReqFmt), .ReqFrm(ReqFrm), .ReqNf(ReqNf), .ReqNX(ReqNX),
        .FrXs(FrXs), .FrXe(FrXe), .FrXm(FrXm), .FrXNaN(FrXNaN), .FrXSNaN(FrXSNaN),
        .FrFmt(FrFmt), .FrFrm(FrFrm), .FrNf(FrNf), .FrNX(FrNX),
        .FRound(FRound), .FRoundNV(FRoundNV), .FRoundNX(FRoundNX),
        .RspValid(RspValid), .RspReady(RspReady), .RspRes(RspRes), .RspFlags(RspFlags),
        .RspTag(RspTag), .Flush(Flush), .Busy(Busy)
    );

    // Round a double to an integral double under frm (RNE/RTZ/RDN/RUP/RMM); returns {res, nv, nx}.
    function automatic logic [FLEN+1:0] dp(input fr_req_t r);
        logic [63:0] m, ip, rem, half, n;
        logic [NE-1:0] e;
        logic up, nx;
        int s, p;
        if (r.xnan) return {QNAN, r.xsnan, 1'b0};
        if (r.fmt != FMT_D || r.nf != LOGFLEN'(NF)) return {BOXED, 2'b00};
        s = int'(NF) - (int'(r.xe) - BIAS);
        if (s <= 0) return {r.xs, r.xe, r.xm[NF-1:0], 2'b00};
        m    = 64'(r.xm);
        ip   = m >> s;
        rem  = m & ((64'd1 << s) - 64'd1);
        half = 64'd1 << (s - 1);
        case (r.frm)
            3'd0:    up = (rem > half) || (rem == half && ip[0]);
            3'd2:    up = (rem != 0) && r.xs;
            3'd3:    up = (rem != 0) && !r.xs;
            3'd4:    up = (rem >= half);
            default: up = 1'b0;
        endcase
        n  = ip + 64'(up);
        nx = r.nx && (rem != 0);
        if (n == 0) return {r.xs, 63'd0, 1'b0, nx};
        p = 0;
        for (int b = 0; b < 64; b++) if (n[b]) p = b;
        e = NE'(BIAS + p);
        m = n << (int'(NF) - p);
        return {r.xs, e, m[NF-1:0], 1'b0, nx};
    endfunction

    function automatic fr_req_t rand_req();
        fr_req_t r;
        r.xs    = 1'($urandom);
        r.xe    = NE'(BIAS - 8 + int'($urandom_range(0, NF + 12)));
        r.xm    = {1'b1, NF'({$urandom, $urandom})};
        if ($urandom_range(0, 3) == 0) r.xm[NF-8:0] = '0;
        r.xnan  = ($urandom_range(0, 15) == 0);
        r.xsnan = r.xnan & 1'($urandom);
        r.fmt   = ($urandom_range(0, 7) == 0) ? FMTBITS'($urandom) : FMT_D;
        r.frm   = 3'($urandom_range(0, 4));
        r.nf    = ($urandom_range(0, 7) == 0) ? LOGFLEN'($urandom) : LOGFLEN'(NF);
        r.nx    = 1'($urandom);
        return r;
    endfunction

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            ReqXs[i]    = drv[i].xs;
            ReqXe[i]    = drv[i].xe;
            ReqXm[i]    = drv[i].xm;
            ReqXNaN[i]  = drv[i].xnan;
            ReqXSNaN[i] = drv[i].xsnan;
            ReqFmt[i]   = drv[i].fmt;
            ReqFrm[i]   = drv[i].frm;
            ReqNf[i]    = drv[i].nf;
            ReqNX[i]    = drv[i].nx;
        end
    end

    always_comb begin
        w_fr.xs    = FrXs;
        w_fr.xe    = FrXe;
        w_fr.xm    = FrXm;
        w_fr.xnan  = FrXNaN;
        w_fr.xsnan = FrXSNaN;
        w_fr.fmt   = FrFmt;
        w_fr.frm   = FrFrm;
        w_fr.nf    = FrNf;
        w_fr.nx    = FrNX;
    end

    always_comb {FRound, FRoundNV, FRoundNX} = dp(w_fr);

    task automatic chk(input bit ok, input string nm, input logic [CW-1:0] act, input logic [CW-1:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
        end
    endtask

    // One cycle: inputs already driven at the falling edge; sample, check acceptance, record.
    task automatic step();
        logic [1:0] g, exp_rdy;
        logic [FLEN+1:0] d;
        exp_t e;
        #4;
        g = 2'b00;
        if (ReqValid != 2'b00) begin
`ifdef FROUND_SCHED_RR_EN
            if (ReqValid[m_ptr]) g[m_ptr] = 1'b1;
            else                 g[~m_ptr] = 1'b1;
`else
            g = ReqValid[0] ? 2'b01 : 2'b10;
`endif
        end
        exp_rdy = (!Flush && (exp_q.size() < 2 || RspReady)) ? g : 2'b00;
        chk(ReqReady == exp_rdy, "req_ready", CW'(ReqReady), CW'(exp_rdy));
        last_rdy  = ReqReady;
        last_vld  = RspValid;
        last_res  = RspRes;
        last_fl   = RspFlags;
        last_tag  = RspTag;
        last_busy = Busy;
        if (exp_rdy != 2'b00) begin
            d       = dp(drv[exp_rdy[1]]);
            e.res   = d[FLEN+1:2];
            e.flags = d[1:0];
            e.tag   = exp_rdy[1];
            exp_q.push_back(e);
`ifdef FROUND_SCHED_RR_EN
            m_ptr = ~m_ptr;
`endif
        end
        if (Flush) begin
            @(posedge clk);
            #1;
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    // Monitor: pops on every response handshake and checks hold stability under backpressure.
    initial begin : mon
        exp_t e;
        logic hold;
        logic [FLEN-1:0] h_res;
        logic [1:0] h_fl;
        logic h_tag;
        hold = 1'b0;
        forever begin
            @(negedge clk);
            #3;
            if (reset) begin
                hold = 1'b0;
                continue;
            end
            if (hold) begin
                chk(RspValid && RspRes == h_res && RspFlags == h_fl && RspTag == h_tag, "rsp_stable",
                    {RspRes, RspFlags, RspTag}, {h_res, h_fl, h_tag});
            end
            if (RspValid && RspReady) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "rsp_unexpected", {RspRes, RspFlags, RspTag}, '0);
                end else begin
                    e = exp_q.pop_front();
                    chk(RspRes == e.res && RspFlags == e.flags && RspTag == e.tag, "rsp",
                        {RspRes, RspFlags, RspTag}, {e.res, e.flags, e.tag});
                end
            end
            hold  = RspValid && !RspReady && !Flush;
            h_res = RspRes;
            h_fl  = RspFlags;
            h_tag = RspTag;
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
`ifdef FROUND_SCHED_RR_EN
        want = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
        want = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
        reset    = 1'b1;
        ReqValid = 2'b00;
        RspReady = 1'b1;
        Flush    = 1'b0;
        m_ptr    = 1'b0;
        drv[0]   = rand_req();
        drv[1]   = rand_req();
        repeat (2) @(negedge clk);
        ReqValid = 2'b11;
        #1;
        chk(RspValid == 1'b0, "reset_rspvalid", CW'(RspValid), '0);
        chk(ReqReady == 2'b00, "reset_reqready", CW'(ReqReady), '0);
        chk(Busy == 1'b0, "reset_busy", CW'(Busy), '0);
        chk(RspFlags == 2'b00, "reset_flags", CW'(RspFlags), '0);
        chk(RspRes == '0, "reset_res", CW'(RspRes), '0);
        @(negedge clk);
        reset = 1'b0;

        // Contention from a fresh pointer.
        for (int k = 0; k < 4; k++) begin
            drv[0] = rand_req();
            drv[1] = rand_req();
            ReqValid = 2'b11;
            step();
            chk(last_rdy == want[k], "contention", CW'(last_rdy), CW'(want[k]));
        end
        ReqValid = 2'b00;
        repeat (4) step();

        // Single op: 2.5 under RNE with inexact enabled.
        drv[0].xs = 1'b0;  drv[0].xe = 11'h400;  drv[0].xm = {1'b1, 52'h4_0000_0000_0000};
        drv[0].xnan = 1'b0; drv[0].xsnan = 1'b0; drv[0].fmt = FMT_D; drv[0].frm = 3'd0;
        drv[0].nf = LOGFLEN'(NF); drv[0].nx = 1'b1;
        ReqValid = 2'b01;
        step();
        chk(last_rdy == 2'b01, "single_accept", CW'(last_rdy), CW'(2'b01));
        ReqValid = 2'b00;
        step();
        chk(last_vld == 1'b0, "single_lat1", CW'(last_vld), '0);
        step();
        chk(last_vld && last_res == 64'h4000_0000_0000_0000 && last_fl == 2'b01 && last_tag == 1'b0,
            "single_rsp", {last_res, last_fl, last_tag}, {64'h4000_0000_0000_0000, 2'b01, 1'b0});
        repeat (2) step();

        // Backpressure: exactly two ops held, then released in order.
        RspReady = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drv[0] = rand_req();
            drv[1] = rand_req();
            ReqValid = 2'b11;
            step();
            if (k < 2) chk(last_rdy != 2'b00, "bp_accept", CW'(last_rdy), CW'(2'b11));
            else       chk(last_rdy == 2'b00, "bp_stall", CW'(last_rdy), '0);
        end
        chk(last_busy && last_vld, "bp_held", CW'({last_busy, last_vld}), CW'(2'b11));
        RspReady = 1'b1;
        ReqValid = 2'b00;
        repeat (4) step();

        // Flush with both stages full.
        RspReady = 1'b0;
        ReqValid = 2'b11;
        repeat (2) step();
        Flush = 1'b1;
        step();
        chk(last_rdy == 2'b00, "flush_reqready", CW'(last_rdy), '0);
        Flush    = 1'b0;
        ReqValid = 2'b00;
        RspReady = 1'b1;
        step();
        chk(!last_busy && !last_vld, "flush_empty", CW'({last_busy, last_vld}), '0);
        drv[1]   = rand_req();
        ReqValid = 2'b10;
        step();
        ReqValid = 2'b00;
        repeat (3) step();

        // Signalling NaN from requester 1.
        drv[1] = rand_req();
        drv[1].xnan = 1'b1;
        drv[1].xsnan = 1'b1;
        ReqValid = 2'b10;
        step();
        ReqValid = 2'b00;
        repeat (2) step();
        chk(last_vld && last_fl == 2'b10 && last_tag == 1'b1, "snan_rsp",
            CW'({last_vld, last_fl, last_tag}), CW'({1'b1, 2'b10, 1'b1}));

        // Random traffic with backpressure and occasional flushes.
        for (int k = 0; k < 400; k++) begin
            drv[0]   = rand_req();
            drv[1]   = rand_req();
            ReqValid = 2'($urandom);
            RspReady = ($urandom_range(0, 3) != 0);
            Flush    = ($urandom_range(0, 31) == 0);
            step();
        end
        Flush = 1'b0;

        // Asynchronous reset with ops in flight.
        RspReady = 1'b0;
        ReqValid = 2'b11;
        repeat (2) step();
        #2;
        reset = 1'b1;
        #1;
        chk(RspValid == 1'b0, "midreset_rspvalid", CW'(RspValid), '0);
        chk(ReqReady == 2'b00, "midreset_reqready", CW'(ReqReady), '0);
        chk(Busy == 1'b0, "midreset_busy", CW'(Busy), '0);
        exp_q.delete();
        m_ptr = 1'b0;
        @(negedge clk);
        reset    = 1'b0;
        RspReady = 1'b1;
        ReqValid = 2'b11;
        step();
        chk(last_rdy == 2'b01, "ptr_after_reset", CW'(last_rdy), CW'(2'b01));

        // Drain, bounded.
        ReqValid = 2'b00;
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) step();
        step();
        chk(exp_q.size() == 0, "drain", CW'(exp_q.size()), '0);
        chk(Busy == 1'b0, "final_idle", CW'(Busy), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fround_sched.md
FROUND_SCHED -- requirements
Module: fround_sched

Interface
REQ-001 SHALL have parameter FLEN, default 64, meaning packed result width.
REQ-002 SHALL have parameter NE, default 11, meaning exponent width.
REQ-003 SHALL have parameter NF, default 52, meaning fraction width.
REQ-004 SHALL have parameter FMTBITS, default 2, meaning format-select width.
REQ-005 SHALL have parameter LOGFLEN, default 6, meaning width of Nf.
REQ-006 SHALL have one clock and an asynchronous, active-high reset, with ports as follows.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have the following request ports, where i is 0..1:
- ReqValid  in  [1:0]  request valid.
- ReqReady  out  [1:0]  request accepted.
- ReqXs  in  [1:0]  sign.
- ReqXe  in  [1:0][NE-1:0]  biased exponent.
- ReqXm  in  [1:0][NF:0]  U1.NF significand.
- ReqXNaN, ReqXSNaN  in  [1:0]  NaN / signalling NaN.
- ReqFmt  in  [1:0][FMTBITS-1:0]  format.
- ReqFrm  in  [1:0][2:0]  rounding mode.
- ReqNf  in  [1:0][LOGFLEN-1:0]  fraction bits.
- ReqNX  in  [1:0]  froundnx (inexact enabled).
REQ-008 SHALL have the following ports to and from the shared round-to-integer datapath:
- FrXs, FrXe, FrXm, FrXNaN, FrXSNaN, FrFmt, FrFrm, FrNf, FrNX  out  widths as Req*  operands.
- FRound  in  FLEN  result.
- FRoundNV, FRoundNX  in  1  flags.
REQ-009 SHALL have the following response and control ports:
- RspValid  out  1  response valid.
- RspReady  in  1  response accepted.
- RspRes  out  FLEN  result.
- RspFlags  out  2  {NV,NX}.
- RspTag  out  1  originating requester.
- Flush  in  1  kill in-flight ops.
- Busy  out  1  any stage valid.

Function
REQ-010 SHALL form two pipeline stages: S1 (operand register driving Fr*) and S2 (result register capturing FRound, flags and tag); latency is exactly 2 cycles from handshake to RspValid when RspReady stays 1.
REQ-011 SHALL define Adv2 = ~S2Valid | RspReady and Adv1 = ~S1Valid | Adv2.
REQ-012 SHALL assert ReqReady[i] only when Grant[i] & Adv1, and ReqReady SHALL NOT depend combinationally on RspReady except through Adv1.
REQ-013 SHALL make Grant one-hot or zero, and only among asserted ReqValid bits.
REQ-014 SHALL load S1 on any ReqValid[i] & ReqReady[i] handshake, clear S1Valid when Adv1 with no handshake, and hold S1 otherwise.
REQ-015 SHALL load S2 from the datapath outputs and the S1 tag when S1Valid & Adv2, clear S2Valid when RspReady with no S1Valid, and hold S2 otherwise.
REQ-016 SHALL keep RspRes, RspFlags and RspTag stable while RspValid & ~RspReady.
REQ-017 SHALL, when Flush is high, clear S1Valid and S2Valid on the next edge, accept no request that cycle (ReqReady=0), and leave the arbitration pointer unchanged.
REQ-018 SHALL drive Fr* from S1 contents even when S1Valid=0, with no functional effect.
REQ-019 SHALL drive Busy = S1Valid | S2Valid.
REQ-020 SHALL sustain a throughput of one op per cycle with no bubble when RspReady=1.

Reset
REQ-021 SHALL on reset clear S1Valid and S2Valid, set the pointer to requester 0, and drive ReqReady, RspValid, Busy and RspFlags to 0 and RspRes to 0.
REQ-022 SHALL on reset asserted mid-operation discard all in-flight ops, with no response produced for them.

Configuration
REQ-023 SHALL, with FROUND_SCHED_RR_EN defined, arbitrate round-robin: a 1-bit pointer names the preferred requester and flips to the other requester after each accepted handshake.
REQ-024 SHALL, with FROUND_SCHED_RR_EN undefined, use fixed priority with requester 0 always winning; no pointer register is present.

Structure
REQ-025 SHALL place the request-bundle struct (Xs, Xe, Xm, XNaN, XSNaN, Fmt, Frm, Nf, NX) and the 2-bit flag-field typedef in a shared package fround_sched_pkg.
REQ-026 SHALL contain the arbiter as one sub-module, fround_sched_arb (ReqValid, pointer, Adv1, Flush -> Grant), and SHALL NOT instantiate the datapath.

Verification
REQ-027 SHALL cover single op: requester 0 sends double 2.5 (Xe=0x400, Xm=1.01b), RNE, NX=1 -> RspValid two cycles later, RspTag=0, FRound 0x4000000000000000 passed through, RspFlags=01.
REQ-028 SHALL cover contention with RR_EN: both requesters valid for 4 cycles -> accepted tags 0,1,0,1; without RR_EN -> 0,0,0,0.
REQ-029 SHALL cover backpressure: RspReady=0 for 3 cycles with continuous requests -> exactly 2 ops held, ReqReady=0, RspRes stable; release -> responses in order with no loss.
REQ-030 SHALL cover Flush with S1 and S2 full -> next cycle Busy=0, RspValid=0; the next request completes normally.
REQ-031 SHALL cover reset asserted asynchronously mid-op -> RspValid and ReqReady are 0 immediately, and the pointer reads requester 0.
REQ-032 SHALL cover sNaN input on requester 1 -> RspFlags=10 and RspTag=1.
